// File: rtl/zu3_pkg.sv
// Shared types and defaults for the AUP-ZU3 input conditioning block.
package zu3_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        BTN  = 2'd2
    } rst_state_t;

    localparam int unsigned CLK_HZ      = 50000000;
    localparam int unsigned DEBOUNCE_MS = 10;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/zu3_debounce.sv
// One input channel: 2-flop synchroniser, stability counter and accepted level.
module zu3_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RESET_VAL,
    input  logic din,
    output logic stable,
    output logic stable_next
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign sync = sync_q[1];

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {2{RESET_VAL}};
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], din};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable      = stable_q;
    assign stable_next = stable_d;

endmodule

// File: rtl/zu3_input_cond.sv
// Board input conditioning: debounced buttons/switches, press pulses and emu reset sequencer.
module zu3_input_cond
    import zu3_pkg::*;
#(
    parameter int unsigned NUM_BTN           = 4,
    parameter int unsigned NUM_SW            = 8,
    parameter int unsigned DEBOUNCE_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
    parameter int unsigned RESET_HOLD_CYCLES = 1024,
    parameter int unsigned RST_BTN           = 0
) (
    input  logic               CLK_50M,
    input  logic               RESET_N,
    input  logic [NUM_BTN-1:0] BUTTONS_RAW,
    input  logic [NUM_SW-1:0]  SWITCHES_RAW,
    output logic [NUM_BTN-1:0] BTN_DB,
    output logic [NUM_BTN-1:0] BTN_PRESS,
    output logic [NUM_SW-1:0]  SW_DB,
    output logic               EMU_RESET,
    output logic [1:0]         RST_STATE
);

    localparam int unsigned NCH = NUM_BTN + NUM_SW;
    localparam int unsigned HW  = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    localparam logic [1:0] ST_HOLD = 2'(HOLD);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_BTN  = 2'(BTN);

    logic [1:0]     rst_sync_q;
    logic           rst_n;
    logic [NCH-1:0] raw_all, db_all, db_next_all;
    logic [NUM_BTN-1:0] btn_db_q;
    logic [1:0]     state_q, state_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           emu_reset_q;
    logic           rst_btn;
    logic           unused_db_next;

    // Asynchronous assertion, deassertion released two clocks later.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Buttons are inverted here so everything downstream is active-high.
    assign raw_all = {SWITCHES_RAW, ~BUTTONS_RAW};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        zu3_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (CLK_50M),
            .rst_n      (rst_n),
            .RESET_VAL  (1'b0),
            .din        (raw_all[i]),
            .stable     (db_all[i]),
            .stable_next(db_next_all[i])
        );
    end

    assign BTN_DB    = db_all[NUM_BTN-1:0];
    assign SW_DB     = db_all[NUM_BTN +: NUM_SW];
    assign BTN_PRESS = BTN_DB & ~btn_db_q;

    // The sequencer acts on the level being committed this edge, so EMU_RESET
    // and RST_STATE change on the same clock as BTN_DB[RST_BTN].
    assign rst_btn        = db_next_all[RST_BTN];
    assign unused_db_next = ^db_next_all;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (rst_btn) begin
                    state_d    = ST_BTN;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (rst_btn) begin
                    state_d = ST_BTN;
                end
            end
            ST_BTN: begin
                hold_cnt_d = '0;
                if (!rst_btn) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            emu_reset_q <= 1'b1;
            btn_db_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            emu_reset_q <= (state_d != ST_RUN);
            btn_db_q    <= BTN_DB;
        end
    end

    assign EMU_RESET = emu_reset_q;
    assign RST_STATE = state_q;

endmodule
